// File: rtl/simd_pkg.sv
// Shared constants for the SIMD issue front-end and its result buffer.
package simd_pkg;
  localparam int LANE_W    = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_TAG_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef logic [1:0] simd_op_t;
endpackage

// File: rtl/simd_result_fifo.sv
// In-order result buffer; DEPTH must be a power of two so pointers wrap naturally.
module simd_result_fifo
  import simd_pkg::*;
#(
  parameter int WIDTH = DEF_TAG_W + LANE_W * DEF_LANES,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == DEPTH_C);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end
endmodule

// File: rtl/simd_issue_ctrl.sv
// Issues tagged vector ops to a 1-cycle SIMD ALU and buffers results in order.
// Admission reserves a FIFO slot per op, so the non-stallable ALU never loses a result.
module simd_issue_ctrl
  import simd_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int RES_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [LANE_W*LANES-1:0] in_a,
  input  logic [LANE_W*LANES-1:0] in_b,
  output logic [1:0]              alu_op,
  output logic [LANE_W*LANES-1:0] alu_a,
  output logic [LANE_W*LANES-1:0] alu_b,
  input  logic [LANE_W*LANES-1:0] alu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [LANE_W*LANES-1:0] out_result,
  output logic                    busy
);
  localparam int DW = LANE_W * LANES;
  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(RES_DEPTH);

  logic             r_inflight_v;
  logic [TAG_W-1:0] r_inflight_tag;
  logic [AW:0]      w_count;
  logic [AW:0]      w_occ;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic [TAG_W+DW-1:0] w_rdata;

  assign alu_op = in_op;
  assign alu_a  = in_a;
  assign alu_b  = in_b;

  // Credit uses registered state only; a same-cycle pop frees a slot next cycle.
  assign w_occ    = w_count + {{AW{1'b0}}, r_inflight_v};
  assign in_ready = !w_full && (w_occ < DEPTH_C);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight_v   <= 1'b0;
      r_inflight_tag <= '0;
    end else begin
      r_inflight_v <= w_accept;
      if (w_accept) r_inflight_tag <= in_tag;
    end
  end

  simd_result_fifo #(
    .WIDTH (TAG_W + DW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_inflight_v),
    .wdata ({r_inflight_tag, alu_result}),
    .pop   (out_ready),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid  = !w_empty;
  assign out_tag    = w_rdata[DW +: TAG_W];
  assign out_result = w_rdata[DW-1:0];
  assign busy       = r_inflight_v || !w_empty;
endmodule
